// File: rtl/n64adv2_dram_arbiter_pkg.sv
// Shared encodings for the n64adv2 DRAM arbiter: command ops, FSM states, winner one-hots and default widths.
package n64adv2_dram_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF    = 24;
    localparam int unsigned LEN_W_DEF     = 8;
    localparam int unsigned WR_MAXAGE_DEF = 64;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_RD   = 2'd1,
        CMD_WR   = 2'd2,
        CMD_REF  = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ZLEN  = 2'd3
    } arb_state_e;

    // Winner one-hot layout is {wr, rd, ref}; grants reuse the same layout.
    localparam int unsigned GNT_REF = 0;
    localparam int unsigned GNT_RD  = 1;
    localparam int unsigned GNT_WR  = 2;

    localparam logic [2:0] WIN_NONE = 3'b000;
    localparam logic [2:0] WIN_REF  = 3'b001;
    localparam logic [2:0] WIN_RD   = 3'b010;
    localparam logic [2:0] WIN_WR   = 3'b100;

    function automatic cmd_op_e win_to_op(input logic [2:0] win);
        cmd_op_e op;
        case (win)
            WIN_REF: op = CMD_REF;
            WIN_RD:  op = CMD_RD;
            WIN_WR:  op = CMD_WR;
            default: op = CMD_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/n64adv2_dram_arbiter_prio.sv
// n64adv2_arb_prio: combinational winner select, REF > RD > WR, or REF > WR > RD once WR is aged.
module n64adv2_arb_prio
    import n64adv2_dram_arbiter_pkg::*;
(
    input  logic       ref_req,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic       aged,
    output logic [2:0] win
);

    // Fixed-priority pick; aging only swaps the RD/WR order.
    always_comb begin
        win = WIN_NONE;
        if (ref_req) begin
            win = WIN_REF;
        end else if (aged && wr_req) begin
            win = WIN_WR;
        end else if (rd_req) begin
            win = WIN_RD;
        end else if (wr_req) begin
            win = WIN_WR;
        end else begin
            win = WIN_NONE;
        end
    end

endmodule

// File: rtl/n64adv2_dram_arbiter.sv
// n64adv2_dram_arbiter: shares the SDRAM command port between refresh, line fetcher and line writer.
// Define ARB_WR_AGE_EN to promote a waiting WR above RD after WR_MAXAGE cycles.
module n64adv2_dram_arbiter
    import n64adv2_dram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned LEN_W     = LEN_W_DEF
`ifdef ARB_WR_AGE_EN
    ,
    parameter int unsigned WR_MAXAGE = WR_MAXAGE_DEF
`endif
) (
    input  logic              DRAM_CLK_i,
    input  logic              DRAM_RST_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    output logic              rd_gnt_o,
    output logic              rd_done_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LEN_W-1:0]  wr_len_i,
    output logic              wr_gnt_o,
    output logic              wr_done_o,
    input  logic              ref_req_i,
    output logic              ref_gnt_o,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [1:0]        cmd_op_o,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [LEN_W-1:0]  cmd_len_o,
    input  logic              cmd_done_i,
    output logic              busy_o
);

    arb_state_e        state_r, state_s;
    cmd_op_e           owner_r, owner_s;
    cmd_op_e           cmd_op_r, cmd_op_s;
    logic              cmd_valid_r, cmd_valid_s;
    logic [ADDR_W-1:0] cmd_addr_r, cmd_addr_s;
    logic [LEN_W-1:0]  cmd_len_r, cmd_len_s;
    logic [2:0]        gnt_r, gnt_s;
    logic              rd_done_r, rd_done_s;
    logic              wr_done_r, wr_done_s;
    logic              busy_r, busy_s;

    logic [2:0]        win_s;
    logic              aged_s;
    cmd_op_e           win_op_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [LEN_W-1:0]  win_len_s;

`ifdef ARB_WR_AGE_EN
    localparam int unsigned AGE_W = $clog2(WR_MAXAGE + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WR_MAXAGE);

    logic [AGE_W-1:0] age_r;

    // Saturating count of cycles WR has waited while someone else holds or contends for the port.
    always_ff @(posedge DRAM_CLK_i) begin
        if (DRAM_RST_i) begin
            age_r <= {AGE_W{1'b0}};
        end else if (gnt_r[GNT_WR]) begin
            age_r <= {AGE_W{1'b0}};
        end else if (wr_req_i && (state_r != ST_ZLEN) && (owner_r != CMD_WR) && (age_r != AGE_MAX)) begin
            age_r <= age_r + AGE_W'(1);
        end
    end

    assign aged_s = (age_r == AGE_MAX);
`else
    assign aged_s = 1'b0;
`endif

    n64adv2_arb_prio u_prio (
        .ref_req (ref_req_i),
        .rd_req  (rd_req_i),
        .wr_req  (wr_req_i),
        .aged    (aged_s),
        .win     (win_s)
    );

    // Route the winner's burst fields; refresh carries address 0 and length 0.
    always_comb begin
        win_op_s   = win_to_op(win_s);
        win_addr_s = {ADDR_W{1'b0}};
        win_len_s  = {LEN_W{1'b0}};
        case (win_s)
            WIN_RD: begin
                win_addr_s = rd_addr_i;
                win_len_s  = rd_len_i;
            end
            WIN_WR: begin
                win_addr_s = wr_addr_i;
                win_len_s  = wr_len_i;
            end
            default: begin
                win_addr_s = {ADDR_W{1'b0}};
                win_len_s  = {LEN_W{1'b0}};
            end
        endcase
    end

    // Next state, command fields and pulses; zero-length bursts skip the controller via ZLEN.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        cmd_valid_s = cmd_valid_r;
        cmd_op_s    = cmd_op_r;
        cmd_addr_s  = cmd_addr_r;
        cmd_len_s   = cmd_len_r;
        gnt_s       = WIN_NONE;
        rd_done_s   = 1'b0;
        wr_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_s != WIN_NONE) begin
                    gnt_s   = win_s;
                    owner_s = win_op_s;
                    if ((win_op_s != CMD_REF) && (win_len_s == {LEN_W{1'b0}})) begin
                        state_s = ST_ZLEN;
                    end else begin
                        cmd_valid_s = 1'b1;
                        cmd_op_s    = win_op_s;
                        cmd_addr_s  = win_addr_s;
                        cmd_len_s   = win_len_s;
                        state_s     = ST_ISSUE;
                    end
                end else begin
                    owner_s = CMD_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready_i) begin
                    cmd_valid_s = 1'b0;
                    state_s     = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (cmd_done_i) begin
                    rd_done_s = (owner_r == CMD_RD);
                    wr_done_s = (owner_r == CMD_WR);
                    owner_s   = CMD_IDLE;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ZLEN: begin
                rd_done_s = (owner_r == CMD_RD);
                wr_done_s = (owner_r == CMD_WR);
                owner_s   = CMD_IDLE;
                state_s   = ST_IDLE;
            end
            default: begin
                owner_s     = CMD_IDLE;
                cmd_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset abandons any burst without a done pulse.
    always_ff @(posedge DRAM_CLK_i) begin
        if (DRAM_RST_i) begin
            state_r     <= ST_IDLE;
            owner_r     <= CMD_IDLE;
            cmd_valid_r <= 1'b0;
            cmd_op_r    <= CMD_IDLE;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_len_r   <= {LEN_W{1'b0}};
            gnt_r       <= WIN_NONE;
            rd_done_r   <= 1'b0;
            wr_done_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            cmd_valid_r <= cmd_valid_s;
            cmd_op_r    <= cmd_op_s;
            cmd_addr_r  <= cmd_addr_s;
            cmd_len_r   <= cmd_len_s;
            gnt_r       <= gnt_s;
            rd_done_r   <= rd_done_s;
            wr_done_r   <= wr_done_s;
            busy_r      <= busy_s;
        end
    end

    assign rd_gnt_o    = gnt_r[GNT_RD];
    assign wr_gnt_o    = gnt_r[GNT_WR];
    assign ref_gnt_o   = gnt_r[GNT_REF];
    assign rd_done_o   = rd_done_r;
    assign wr_done_o   = wr_done_r;
    assign cmd_valid_o = cmd_valid_r;
    assign cmd_op_o    = cmd_op_r;
    assign cmd_addr_o  = cmd_addr_r;
    assign cmd_len_o   = cmd_len_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_n64adv2_dram_arbiter.sv
// Bench for n64adv2_dram_arbiter: transaction-level reference model checked every cycle, plus directed pins.
// Honours ARB_WR_AGE_EN the same way as the design.
module tb_n64adv2_dram_arbiter;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 8;
    localparam int MAXAGE = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              rd_req, wr_req, ref_req;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [LEN_W-1:0]  rd_len, wr_len;
    logic              cmd_ready, cmd_done;
    logic              rd_gnt, rd_done, wr_gnt, wr_done, ref_gnt, cmd_valid, busy;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_lat = 0;
    int done_lat = 0;

    n64adv2_dram_arbiter dut (
        .DRAM_CLK_i  (clk),
        .DRAM_RST_i  (rst),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_len_i    (rd_len),
        .rd_gnt_o    (rd_gnt),
        .rd_done_o   (rd_done),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_len_i    (wr_len),
        .wr_gnt_o    (wr_gnt),
        .wr_done_o   (wr_done),
        .ref_req_i   (ref_req),
        .ref_gnt_o   (ref_gnt),
        .cmd_valid_o (cmd_valid),
        .cmd_ready_i (cmd_ready),
        .cmd_op_o    (cmd_op),
        .cmd_addr_o  (cmd_addr),
        .cmd_len_o   (cmd_len),
        .cmd_done_i  (cmd_done),
        .busy_o      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: who owns the port and what the outputs must be next cycle.
    // phase 0 free, 1 command offered, 2 burst running, 3 empty burst finishing; who 1 rd, 2 wr, 3 ref.
    int                m_phase = 0;
    int                m_who = 0;
    int                m_age = 0;
    logic              e_valid = 1'b0;
    int                e_op = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [LEN_W-1:0]  e_len = '0;
    logic              e_rd_gnt = 1'b0, e_wr_gnt = 1'b0, e_ref_gnt = 1'b0;
    logic              e_rd_done = 1'b0, e_wr_done = 1'b0;

    task automatic model_step();
        logic wr_gnt_now;
        logic aged;
        int   nxt_age;
        int   who;
        int   len;
        wr_gnt_now = e_wr_gnt;
        {e_rd_gnt, e_wr_gnt, e_ref_gnt, e_rd_done, e_wr_done} = 5'b00000;
        if (rst) begin
            m_phase = 0; m_who = 0; m_age = 0;
            e_valid = 1'b0; e_op = 0; e_addr = '0; e_len = '0;
        end else begin
            nxt_age = m_age;
            aged    = 1'b0;
`ifdef ARB_WR_AGE_EN
            aged = (m_age >= MAXAGE);
            if (wr_gnt_now) nxt_age = 0;
            else if (wr_req && m_phase != 3 && m_who != 2) nxt_age = (m_age + 1 > MAXAGE) ? MAXAGE : m_age + 1;
`endif
            if (m_phase == 0) begin
                who = ref_req ? 3 : (aged && wr_req) ? 2 : rd_req ? 1 : wr_req ? 2 : 0;
                if (who != 0) begin
                    m_who = who;
                    e_rd_gnt  = (who == 1);
                    e_wr_gnt  = (who == 2);
                    e_ref_gnt = (who == 3);
                    len = (who == 1) ? int'(rd_len) : (who == 2) ? int'(wr_len) : 0;
                    if (who != 3 && len == 0) begin
                        m_phase = 3;
                    end else begin
                        m_phase = 1;
                        e_valid = 1'b1;
                        e_op    = who;
                        e_addr  = (who == 1) ? rd_addr : (who == 2) ? wr_addr : '0;
                        e_len   = LEN_W'(len);
                    end
                end
            end else if (m_phase == 1) begin
                if (cmd_ready) begin e_valid = 1'b0; m_phase = 2; end
            end else if (m_phase == 3 || (m_phase == 2 && cmd_done)) begin
                e_rd_done = (m_who == 1);
                e_wr_done = (m_who == 2);
                m_who = 0;
                m_phase = 0;
            end
            m_age = nxt_age;
        end
    endtask

    // Compare process: advance the model on each edge, check the DUT 1 time unit later.
    initial begin : scoreboard
        forever begin
            @(posedge clk);
            model_step();
            cyc++;
            #1;
            chk("rd_gnt", rd_gnt, e_rd_gnt);
            chk("wr_gnt", wr_gnt, e_wr_gnt);
            chk("ref_gnt", ref_gnt, e_ref_gnt);
            chk("rd_done", rd_done, e_rd_done);
            chk("wr_done", wr_done, e_wr_done);
            chk("cmd_valid", cmd_valid, e_valid);
            chk("busy", busy, (m_phase != 0));
            if (e_valid) begin
                chk("cmd_op", cmd_op, e_op);
                chk("cmd_addr", cmd_addr, e_addr);
                chk("cmd_len", cmd_len, e_len);
            end
        end
    end

    // SDRAM controller stand-in: accepts after ready_lat offered cycles, signals done done_lat cycles later.
    initial begin : ctl
        int vcnt;
        int dcnt;
        vcnt = 0;
        dcnt = -1;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        forever begin
            @(negedge clk);
            cmd_ready = 1'b0;
            cmd_done  = 1'b0;
            if (dcnt >= 0) begin
                if (dcnt == 0) cmd_done = 1'b1;
                dcnt--;
            end else if (cmd_valid === 1'b1) begin
                if (vcnt >= ready_lat) begin
                    cmd_ready = 1'b1;
                    vcnt = 0;
                    dcnt = done_lat;
                end else begin
                    vcnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic sig(input int sel);
        logic v;
        case (sel)
            0:       v = rd_gnt;
            1:       v = wr_gnt;
            2:       v = ref_gnt;
            3:       v = rd_done;
            4:       v = wr_done;
            5:       v = !cmd_valid;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    task automatic wait_for(input string name, input int sel, input int limit, output int waited);
        waited = 0;
        while (sig(sel) !== 1'b1 && waited < limit) begin
            step(1);
            waited++;
        end
        chk(name, sig(sel), 1'b1);
    endtask

    initial begin : stim
        int w;
        int cnt;
        logic seen;
        rst = 1'b1;
        rd_req = 1'b0; wr_req = 1'b0; ref_req = 1'b0;
        rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
        step(3);
        chk("reset_flags", {rd_gnt, rd_done, wr_gnt, wr_done, ref_gnt, cmd_valid, busy, cmd_op}, 32'd0);
        chk("reset_addr", cmd_addr, 32'd0);
        chk("reset_len", cmd_len, 32'd0);
        rst = 1'b0;
        step(2);

        // RD and WR together: RD first, WR one cycle after RD's done pulse.
        rd_addr = 24'h000100; wr_addr = 24'h000200; rd_len = 8'd16; wr_len = 8'd16;
        ready_lat = 0; done_lat = 3;
        rd_req = 1'b1; wr_req = 1'b1;
        wait_for("t1_rd_gnt", 0, 10, w);
        chk("t1_wr_not_first", wr_gnt, 1'b0);
        chk("t1_op_rd", cmd_op, 32'd1);
        chk("t1_addr_rd", cmd_addr, 32'h000100);
        chk("t1_len_rd", cmd_len, 32'd16);
        rd_req = 1'b0;
        wait_for("t1_rd_done", 3, 20, w);
        chk("t1_no_gnt_in_done_cycle", wr_gnt, 1'b0);
        step(1);
        chk("t1_wr_gnt_after_done", wr_gnt, 1'b1);
        chk("t1_op_wr", cmd_op, 32'd2);
        chk("t1_addr_wr", cmd_addr, 32'h000200);
        wr_req = 1'b0;
        wait_for("t1_wr_done", 4, 20, w);
        step(2);

        // REF and RD arrive during a WR burst: nothing until done, then REF ahead of RD.
        wr_addr = 24'h000340; wr_len = 8'd8; done_lat = 6;
        wr_req = 1'b1;
        wait_for("t2_wr_gnt", 1, 10, w);
        wr_req = 1'b0;
        wait_for("t2_in_wait", 5, 10, w);
        ref_req = 1'b1; rd_req = 1'b1; rd_addr = 24'h000500; rd_len = 8'd4;
        step(2);
        chk("t2_no_gnt_in_wait", {ref_gnt, rd_gnt}, 32'd0);
        chk("t2_busy_in_wait", busy, 1'b1);
        wait_for("t2_wr_done", 4, 20, w);
        step(1);
        chk("t2_ref_gnt", ref_gnt, 1'b1);
        chk("t2_rd_held_off", rd_gnt, 1'b0);
        chk("t2_op_ref", cmd_op, 32'd3);
        chk("t2_len_ref", cmd_len, 32'd0);
        ref_req = 1'b0;
        wait_for("t2_rd_gnt", 0, 30, w);
        chk("t2_addr_rd", cmd_addr, 32'h000500);
        rd_req = 1'b0;
        wait_for("t2_rd_done", 3, 30, w);
        step(2);

        // Controller stalls for 10 cycles: command held, single grant.
        ready_lat = 10; done_lat = 1;
        rd_addr = 24'h0abcde; rd_len = 8'd32;
        rd_req = 1'b1;
        wait_for("t3_rd_gnt", 0, 10, w);
        rd_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            chk("t3_valid_held", cmd_valid, 1'b1);
            chk("t3_addr_held", cmd_addr, 32'h0abcde);
            cnt += int'(rd_gnt);
            step(1);
        end
        chk("t3_one_gnt", cnt, 32'd1);
        ready_lat = 0;
        wait_for("t3_rd_done", 3, 20, w);
        step(2);

        // Zero-length WR: grant, done next cycle, never a command.
        wr_addr = 24'h000777; wr_len = 8'd0;
        wr_req = 1'b1;
        wait_for("t4_wr_gnt", 1, 10, w);
        chk("t4_no_cmd_at_gnt", cmd_valid, 1'b0);
        wr_req = 1'b0;
        step(1);
        chk("t4_wr_done_next", wr_done, 1'b1);
        chk("t4_no_cmd_at_done", cmd_valid, 1'b0);
        step(1);
        chk("t4_no_cmd_after", cmd_valid, 1'b0);
        chk("t4_idle_after", busy, 1'b0);
        step(2);

        // Reset while waiting for done: outputs clear, the late done is ignored.
        rd_addr = 24'h001000; rd_len = 8'd8; done_lat = 20;
        rd_req = 1'b1;
        wait_for("t5_rd_gnt", 0, 10, w);
        rd_req = 1'b0;
        wait_for("t5_in_wait", 5, 10, w);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_flags_cleared", {rd_gnt, rd_done, wr_gnt, wr_done, ref_gnt, cmd_valid, busy, cmd_op}, 32'd0);
        chk("t5_addr_cleared", cmd_addr, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            seen |= rd_done;
            step(1);
        end
        chk("t5_no_done_after_reset", seen, 1'b0);

        // Continuous RD against a waiting WR.
        ready_lat = 0; done_lat = 0;
        rd_addr = 24'h002000; rd_len = 8'd2; wr_addr = 24'h003000; wr_len = 8'd2;
        rd_req = 1'b1; wr_req = 1'b1;
`ifdef ARB_WR_AGE_EN
        wait_for("t6_wr_aged_gnt", 1, 120, w);
        chk("t6_wr_not_early", (w >= 65), 1'b1);
        chk("t6_wr_not_late", (w <= 68), 1'b1);
        chk("t6_op_wr", cmd_op, 32'd2);
        chk("t6_addr_wr", cmd_addr, 32'h003000);
        wr_req = 1'b0;
`else
        seen = 1'b0;
        repeat (200) begin
            seen |= wr_gnt;
            step(1);
        end
        chk("t6_wr_starved", seen, 1'b0);
        wr_req = 1'b0;
`endif
        rd_req = 1'b0;
        step(10);
        chk("end_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
